// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl -- registered RV32I/M decode stage.
// Decodes one instruction per fetch->execute transfer into control_t, tagged
// with its PC. Owns load-use stall insertion, multi-cycle MUL/DIV issue
// sequencing, HALT latching and flush.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   fetch handshake (in_ready is combinational)
//   in_instr, in_pc     instruction word and its PC
//   flush               kill held output and any MUL/DIV sequence
//   ex_ready            execute consumes out_* this cycle
//   ex_rd, ex_mem_read  destination / load flag of the instruction in execute
//   out_valid           out_* hold a decoded instruction
//   out_control         decoded control word
//   out_pc, out_instr   registered PC / instruction
//   md_start            one-cycle pulse: start the mul/div unit
//   illegal             one-cycle pulse: accepted instruction not decodable
//   halted              HALT retired; sticky until reset

package decode_stage_pkg;

  typedef logic [31:0] instruction_t;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQUAL, ALU_LT, ALU_LTU, ALU_PASSB,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       alu_src;        // 1: operand b is the immediate
    logic       mem_read;
    logic       mem_write;
    logic       is_branch;
    logic       is_jump;
    logic       reg_write;
    logic       alu_inv_res;    // invert compare result (BNE/BGE/BGEU)
    logic [4:0] write_back_id;
  } control_t;

  // EBREAK is the HALT pattern; every other SYSTEM encoding is illegal.
  localparam instruction_t HALT_INSTR = 32'h0010_0073;

endpackage

module decode_stage_ctrl
  import decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int EN_M       = 1,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  instruction_t    in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic            ex_mem_read,
  output logic            out_valid,
  output control_t        out_control,
  output logic [XLEN-1:0] out_pc,
  output instruction_t    out_instr,
  output logic            md_start,
  output logic            illegal,
  output logic            halted
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {ST_RUN, ST_MD_WAIT, ST_HALT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd, rs1, rs2;

  control_t        dec_ctl;
  logic            dec_ok, dec_md, dec_div, dec_halt, uses_rs2;
  logic            hazard, accept, md_multi;
  logic [CW-1:0]   md_load;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign f3     = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign f7     = in_instr[31:25];

  always_comb begin
    dec_ctl  = '0;
    dec_ok   = 1'b1;
    dec_md   = 1'b0;
    dec_div  = 1'b0;
    dec_halt = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_ctl.alu_op    = ALU_PASSB;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec_ctl.alu_op    = ALU_ADD;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_ctl.alu_op    = ALU_ADD;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.reg_write = 1'b1;
        dec_ctl.is_jump   = 1'b1;
        if (opcode == OPC_JALR && f3 != 3'b000) dec_ok = 1'b0;
      end
      OPC_BRANCH: begin
        uses_rs2          = 1'b1;
        dec_ctl.is_branch = 1'b1;
        case (f3)
          3'b000: dec_ctl.alu_op = ALU_EQUAL;
          3'b001: begin dec_ctl.alu_op = ALU_EQUAL; dec_ctl.alu_inv_res = 1'b1; end
          3'b100: dec_ctl.alu_op = ALU_LT;
          3'b101: begin dec_ctl.alu_op = ALU_LT;    dec_ctl.alu_inv_res = 1'b1; end
          3'b110: dec_ctl.alu_op = ALU_LTU;
          3'b111: begin dec_ctl.alu_op = ALU_LTU;   dec_ctl.alu_inv_res = 1'b1; end
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_ctl.alu_op    = ALU_ADD;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.mem_read  = 1'b1;
        dec_ctl.reg_write = 1'b1;
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) dec_ok = 1'b0;
      end
      OPC_STORE: begin
        uses_rs2          = 1'b1;
        dec_ctl.alu_op    = ALU_ADD;
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.mem_write = 1'b1;
        if (f3 > 3'b010) dec_ok = 1'b0;
      end
      OPC_OPIMM: begin
        dec_ctl.alu_src   = 1'b1;
        dec_ctl.reg_write = 1'b1;
        case (f3)
          3'b000: dec_ctl.alu_op = ALU_ADD;
          3'b010: dec_ctl.alu_op = ALU_SLT;
          3'b011: dec_ctl.alu_op = ALU_SLTU;
          3'b100: dec_ctl.alu_op = ALU_XOR;
          3'b110: dec_ctl.alu_op = ALU_OR;
          3'b111: dec_ctl.alu_op = ALU_AND;
          3'b001: begin
            dec_ctl.alu_op = ALU_SLL;
            if (f7 != 7'b0000000) dec_ok = 1'b0;
          end
          default: begin
            if (f7 == 7'b0000000)      dec_ctl.alu_op = ALU_SRL;
            else if (f7 == 7'b0100000) dec_ctl.alu_op = ALU_SRA;
            else                       dec_ok = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        uses_rs2          = 1'b1;
        dec_ctl.reg_write = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000: dec_ctl.alu_op = ALU_ADD;
              3'b001: dec_ctl.alu_op = ALU_SLL;
              3'b010: dec_ctl.alu_op = ALU_SLT;
              3'b011: dec_ctl.alu_op = ALU_SLTU;
              3'b100: dec_ctl.alu_op = ALU_XOR;
              3'b101: dec_ctl.alu_op = ALU_SRL;
              3'b110: dec_ctl.alu_op = ALU_OR;
              default: dec_ctl.alu_op = ALU_AND;
            endcase
          end
          7'b0100000: begin
            case (f3)
              3'b000:  dec_ctl.alu_op = ALU_SUB;
              3'b101:  dec_ctl.alu_op = ALU_SRA;
              default: dec_ok = 1'b0;
            endcase
          end
          7'b0000001: begin
            if (EN_M != 0) begin
              dec_md  = 1'b1;
              dec_div = f3[2];
              case (f3)
                3'b000: dec_ctl.alu_op = ALU_MUL;
                3'b001: dec_ctl.alu_op = ALU_MULH;
                3'b010: dec_ctl.alu_op = ALU_MULHSU;
                3'b011: dec_ctl.alu_op = ALU_MULHU;
                3'b100: dec_ctl.alu_op = ALU_DIV;
                3'b101: dec_ctl.alu_op = ALU_DIVU;
                3'b110: dec_ctl.alu_op = ALU_REM;
                default: dec_ctl.alu_op = ALU_REMU;
              endcase
            end else begin
              dec_ok = 1'b0;
            end
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OPC_SYSTEM: begin
        if (in_instr == HALT_INSTR) dec_halt = 1'b1;
        else                        dec_ok   = 1'b0;
      end
      default: dec_ok = 1'b0;
    endcase
    // Illegal and HALT both retire as an all-zero control word.
    if (!dec_ok || dec_halt) begin
      dec_ctl = '0;
      dec_md  = 1'b0;
      dec_div = 1'b0;
    end else begin
      dec_ctl.write_back_id = rd;
    end
  end

  // Load-use check works on raw register fields, independent of legality.
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((rs1 == ex_rd) || (uses_rs2 && (rs2 == ex_rd)));

  assign in_ready = (state == ST_RUN) && !flush && !hazard && (!out_valid || ex_ready);
  assign accept   = in_valid && in_ready;

  // Counter holds N-1 after accept so issue stays blocked for exactly N cycles.
  assign md_load  = dec_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
  assign md_multi = dec_div ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_control <= '0;
      out_pc      <= '0;
      out_instr   <= '0;
      md_start    <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      md_start <= 1'b0;
      illegal  <= 1'b0;
      if (flush) begin
        out_valid <= 1'b0;
        cnt       <= '0;
        if (state == ST_MD_WAIT) state <= ST_RUN;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_control <= dec_ctl;
        out_pc      <= in_pc;
        out_instr   <= in_instr;
        illegal     <= !dec_ok;
        md_start    <= dec_md;
        if (dec_halt) begin
          halted <= 1'b1;
          state  <= ST_HALT;
        end else if (dec_md && md_multi) begin
          state <= ST_MD_WAIT;
          cnt   <= md_load;
        end
      end else begin
        if (ex_ready) out_valid <= 1'b0;
        if (state == ST_MD_WAIT) begin
          if (cnt == '0) state <= ST_RUN;
          else           cnt   <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
module tb_decode_stage_ctrl;
  import decode_stage_pkg::*;

  localparam int NI = 3;
  localparam int EN_M_A [NI] = '{1, 1, 0};
  localparam int MUL_A  [NI] = '{3, 1, 3};
  localparam int DIV_A  [NI] = '{33, 4, 33};

  typedef struct {
    control_t    ctl;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ill;
    logic        mds;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, ex_ready, ex_mem_read;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  ex_rd;

  logic        ir [NI];
  logic        ov [NI];
  logic        mds [NI];
  logic        ill [NI];
  logic        hlt [NI];
  control_t    oc [NI];
  logic [31:0] opc [NI];
  logic [31:0] oin [NI];

  int checks = 0;
  int errors = 0;

  // reference model state (per instance)
  logic m_ov [NI];
  logic m_halt [NI];
  int   m_busy [NI];
  exp_t cur [NI];
  logic held [NI];
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  decode_stage_ctrl #(.XLEN(32), .EN_M(EN_M_A[0]), .MUL_CYCLES(MUL_A[0]), .DIV_CYCLES(DIV_A[0])) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .out_valid(ov[0]), .out_control(oc[0]), .out_pc(opc[0]), .out_instr(oin[0]),
    .md_start(mds[0]), .illegal(ill[0]), .halted(hlt[0]));

  decode_stage_ctrl #(.XLEN(32), .EN_M(EN_M_A[1]), .MUL_CYCLES(MUL_A[1]), .DIV_CYCLES(DIV_A[1])) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .out_valid(ov[1]), .out_control(oc[1]), .out_pc(opc[1]), .out_instr(oin[1]),
    .md_start(mds[1]), .illegal(ill[1]), .halted(hlt[1]));

  decode_stage_ctrl #(.XLEN(32), .EN_M(EN_M_A[2]), .MUL_CYCLES(MUL_A[2]), .DIV_CYCLES(DIV_A[2])) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .out_valid(ov[2]), .out_control(oc[2]), .out_pc(opc[2]), .out_instr(oin[2]),
    .md_start(mds[2]), .illegal(ill[2]), .halted(hlt[2]));

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else if (i == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
  endfunction

  task automatic pop(input int i, output exp_t e);
    if (i == 0) e = q0.pop_front();
    else if (i == 1) e = q1.pop_front();
    else e = q2.pop_front();
  endtask

  // Reference decoder: RV32I/M rules from the ISA tables.
  // mdk: 0 none, 1 multiply class, 2 divide class.
  function automatic void ref_dec(input logic [31:0] ins, input int en_m, output control_t c,
                                  output logic bad, output int mdk, output logic h);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    alu_op_t base [8];
    alu_op_t mops [8];
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    mops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    c = '0; bad = 1'b0; mdk = 0; h = 1'b0;
    if (ins == 32'h0010_0073) h = 1'b1;
    else case (op)
      7'h37: begin c.alu_op = ALU_PASSB; c.alu_src = 1; c.reg_write = 1; end
      7'h17: begin c.alu_op = ALU_ADD; c.alu_src = 1; c.reg_write = 1; end
      7'h6F, 7'h67: begin
        c.alu_op = ALU_ADD; c.alu_src = 1; c.reg_write = 1; c.is_jump = 1;
        if (op == 7'h67 && f3 != 0) bad = 1;
      end
      7'h63: begin
        c.is_branch = 1; c.alu_inv_res = f3[0];
        case (f3[2:1])
          2'b00: c.alu_op = ALU_EQUAL;
          2'b10: c.alu_op = ALU_LT;
          2'b11: c.alu_op = ALU_LTU;
          default: bad = 1;
        endcase
      end
      7'h03: begin
        c.alu_op = ALU_ADD; c.alu_src = 1; c.mem_read = 1; c.reg_write = 1;
        bad = (f3 == 3 || f3 > 5);
      end
      7'h23: begin
        c.alu_op = ALU_ADD; c.alu_src = 1; c.mem_write = 1; bad = (f3 > 2);
      end
      7'h13: begin
        c.alu_src = 1; c.reg_write = 1; c.alu_op = base[f3];
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5) begin
          if (f7 == 7'h20) c.alu_op = ALU_SRA;
          else if (f7 != 0) bad = 1;
        end
      end
      7'h33: begin
        c.reg_write = 1;
        if (f7 == 0) c.alu_op = base[f3];
        else if (f7 == 7'h20 && f3 == 0) c.alu_op = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) c.alu_op = ALU_SRA;
        else if (f7 == 1 && en_m != 0) begin c.alu_op = mops[f3]; mdk = f3[2] ? 2 : 1; end
        else bad = 1;
      end
      default: bad = 1;
    endcase
    if (bad || h) begin c = '0; mdk = 0; end
    else c.write_back_id = ins[11:7];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom();
    int k = $urandom_range(0, 15);
    logic [6:0] op;
    int s = $urandom_range(0, 2);
    case (k)
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6F;  3: op = 7'h67;
      4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;
      7, 8, 15: op = 7'h13;
      9, 10, 11: op = 7'h33;
      13: op = 7'h73;
      14: op = 7'h0F;
      default: op = r[6:0];
    endcase
    r[6:0]   = op;
    r[11:7]  = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    if (k inside {7, 8, 9, 10}) r[31:25] = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : r[31:25];
    if (k == 11) r[31:25] = 7'h01;
    if (r == 32'h0010_0073) r = 32'h0050_0093;
    return r;
  endfunction

  // One clock: drive inputs after the edge, check the combinational/state
  // view against the model, then advance the model across the next edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic fl,
                       input logic er, input logic emr, input logic [4:0] erd);
    logic haz, rdy, bad, h;
    logic [4:0] rs1, rs2;
    int mdk, n;
    exp_t e;
    @(posedge clk); #1;
    in_valid = iv; in_instr = ins; in_pc = $urandom() & 32'hFFFF_FFFC;
    flush = fl; ex_ready = er; ex_mem_read = emr; ex_rd = erd;
    #1;
    rs1 = ins[19:15]; rs2 = ins[24:20];
    haz = emr && erd != 0 &&
          (rs1 == erd || ((ins[6:0] inside {7'h33, 7'h23, 7'h63}) && rs2 == erd));
    for (int i = 0; i < NI; i++) begin
      rdy = !m_halt[i] && m_busy[i] == 0 && !fl && !haz && (!m_ov[i] || er);
      chk("in_ready", i, 64'(ir[i]), 64'(rdy));
      chk("out_valid", i, 64'(ov[i]), 64'(m_ov[i]));
      chk("halted", i, 64'(hlt[i]), 64'(m_halt[i]));
      if (fl) begin
        m_ov[i] = 0; m_busy[i] = 0;
      end else if (iv && rdy) begin
        ref_dec(ins, EN_M_A[i], e.ctl, bad, mdk, h);
        e.pc = in_pc; e.instr = ins; e.ill = bad; e.mds = (mdk != 0);
        push(i, e);
        m_ov[i] = 1;
        if (h) m_halt[i] = 1;
        else if (mdk != 0) begin
          n = (mdk == 2) ? DIV_A[i] : MUL_A[i];
          m_busy[i] = (n > 1) ? n : 0;
        end
      end else begin
        if (er) m_ov[i] = 0;
        if (m_busy[i] > 0) m_busy[i]--;
      end
    end
  endtask

  task automatic chk_zero();
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", i, 64'(ov[i]), 64'(0));
      chk("rst_md_start", i, 64'(mds[i]), 64'(0));
      chk("rst_illegal", i, 64'(ill[i]), 64'(0));
      chk("rst_halted", i, 64'(hlt[i]), 64'(0));
      chk("rst_control", i, 64'(oc[i]), 64'(0));
      chk("rst_pc", i, 64'(opc[i]), 64'(0));
      chk("rst_instr", i, 64'(oin[i]), 64'(0));
      chk("rst_in_ready", i, 64'(ir[i]), 64'(1));
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int i = 0; i < NI; i++) begin
      m_ov[i] = 0; m_halt[i] = 0; m_busy[i] = 0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; in_valid = 0; flush = 0; ex_mem_read = 0;
    #1;
    chk_zero();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Scoreboard monitor: pops on each new presentation, checks hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) held[i] = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i] && !held[i]) begin
          if (qsize(i) == 0) begin
            chk("unexpected_output", i, 64'(1), 64'(0));
          end else begin
            pop(i, e);
            cur[i] = e;
            chk("control", i, 64'(oc[i]), 64'(e.ctl));
            chk("out_pc", i, 64'(opc[i]), 64'(e.pc));
            chk("out_instr", i, 64'(oin[i]), 64'(e.instr));
            chk("illegal", i, 64'(ill[i]), 64'(e.ill));
            chk("md_start", i, 64'(mds[i]), 64'(e.mds));
          end
        end else begin
          chk("illegal_idle", i, 64'(ill[i]), 64'(0));
          chk("md_start_idle", i, 64'(mds[i]), 64'(0));
          if (ov[i]) begin
            chk("hold_control", i, 64'(oc[i]), 64'(cur[i].ctl));
            chk("hold_pc", i, 64'(opc[i]), 64'(cur[i].pc));
            chk("hold_instr", i, 64'(oin[i]), 64'(cur[i].instr));
          end
        end
        held[i] = ov[i] && !ex_ready && !flush;
      end
    end
  end

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] ADDI2 = 32'h0070_0113;
  localparam logic [31:0] ADDX  = 32'h0010_8133;
  localparam logic [31:0] DIVI  = 32'h0220_C1B3;
  localparam logic [31:0] HALTI = 32'h0010_0073;

  initial begin
    rst_n = 0; in_valid = 0; flush = 0; ex_ready = 1; ex_mem_read = 0;
    ex_rd = 0; in_instr = 0; in_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    rst_n = 1;

    // basic ADDI, then stall for three cycles with execute not ready
    cycle(1, ADDI, 0, 1, 0, 0);
    cycle(1, ADDI2, 0, 0, 0, 0);
    repeat (3) cycle(1, ADDI2, 0, 0, 0, 0);
    cycle(1, ADDI2, 0, 1, 0, 0);
    cycle(0, ADDI, 0, 1, 0, 0);
    // load-use hazard then release
    cycle(1, ADDX, 0, 1, 1, 5'd1);
    cycle(1, ADDX, 0, 1, 0, 5'd1);
    cycle(0, ADDI, 0, 1, 0, 0);
    // divide sequence with following instructions waiting
    cycle(1, DIVI, 0, 1, 0, 0);
    repeat (40) cycle(1, ADDI, 0, 1, 0, 0);
    // flush on the tenth blocked cycle, with an instruction offered
    cycle(1, DIVI, 0, 1, 0, 0);
    repeat (9) cycle(1, ADDI, 0, 1, 0, 0);
    cycle(1, ADDI, 1, 1, 0, 0);
    repeat (3) cycle(1, ADDI, 0, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 24) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    repeat (3) cycle(0, ADDI, 0, 1, 0, 0);
    for (int i = 0; i < NI; i++) chk("queue_drained", i, 64'(qsize(i)), 64'(0));

    // async reset in the middle of a divide
    cycle(1, DIVI, 0, 1, 0, 0);
    repeat (5) cycle(1, ADDI, 0, 0, 0, 0);
    do_reset();
    cycle(1, ADDI, 0, 1, 0, 0);
    cycle(0, ADDI, 0, 1, 0, 0);

    // HALT is terminal; flush does not leave it
    cycle(1, HALTI, 0, 1, 0, 0);
    cycle(1, ADDI, 1, 1, 0, 0);
    repeat (4) cycle(1, ADDI, 0, 1, 0, 0);
    do_reset();
    cycle(1, ADDI, 0, 1, 0, 0);
    repeat (2) cycle(0, ADDI, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
